// File: rtl/button_event_ctrl_if.sv
// Event stream from the button controller to its consumer (debug control).
// Latency: none, wires only.
// Backpressure: consumer holds i_Evt_Ready low to keep the head event.
//
// Signals:
//   o_Evt_Valid  FIFO head holds an event
//   i_Evt_Ready  consumer accepts the head event this cycle
//   o_Evt_Id     button index of the head event
//   o_Evt_Long   1 = long press, 0 = short press
interface button_event_ctrl_if #(
    parameter int NUM_BTN = 4
);
    localparam int ID_W = $clog2(NUM_BTN);

    logic            o_Evt_Valid;
    logic            i_Evt_Ready;
    logic [ID_W-1:0] o_Evt_Id;
    logic            o_Evt_Long;

    modport master (
        output o_Evt_Valid,
        output o_Evt_Id,
        output o_Evt_Long,
        input  i_Evt_Ready
    );

    modport slave (
        input  o_Evt_Valid,
        input  o_Evt_Id,
        input  o_Evt_Long,
        output i_Evt_Ready
    );
endinterface

// File: rtl/button_event_ctrl.sv
// Turns debounced button levels into queued short/long press events.
// Latency: short event valid 2 edges after release, long event 1 edge after the hold count hits.
// Backpressure: FIFO holds events while not ready; a full FIFO parks one event per button in its pending flag.
//
// Ports:
//   i_Clk, i_Rst_L  clock, asynchronous active-low reset
//   i_Btn           debounced levels, 1 = pressed, synchronous to i_Clk
//   evt             event stream (valid/ready, id, long)
//   o_Overflow      sticky, an event was dropped; i_Clear_Ovf clears it
module button_event_ctrl #(
    parameter int NUM_BTN           = 4,
    parameter int LONG_PRESS_CYCLES = 12500000,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    input  logic [NUM_BTN-1:0]  i_Btn,
    button_event_ctrl_if.master evt,
    output logic                o_Overflow,
    input  logic                i_Clear_Ovf
);
    localparam int ID_W   = $clog2(NUM_BTN);
    localparam int CNT_W  = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, HELD, LONG_DONE} state_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            is_long;
    } evt_t;

    logic [NUM_BTN-1:0] r_Btn_Prev;
    logic [NUM_BTN-1:0] w_Rise;
    state_t             r_State     [NUM_BTN];
    state_t             w_State_Nxt [NUM_BTN];
    logic [CNT_W-1:0]   r_Cnt       [NUM_BTN];
    logic [NUM_BTN-1:0] w_Raise;
    logic [NUM_BTN-1:0] w_Raise_Long;
    logic [NUM_BTN-1:0] r_Pend;
    logic [NUM_BTN-1:0] r_Pend_Long;

    logic               w_Grant_Vld;
    logic [ID_W-1:0]    w_Grant_Id;
    logic               w_Grant_Long;
    logic               w_Pop;
    logic               w_Full;
    logic               w_Wr;
    evt_t               w_Wr_Dat;

    evt_t               r_Mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_Wr_Ptr;
    logic [PTR_W-1:0]   r_Rd_Ptr;
    logic [FCNT_W-1:0]  r_Count;
    evt_t               r_Last;
    evt_t               w_Head;

    assign w_Rise = i_Btn & ~r_Btn_Prev;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) r_Btn_Prev <= '0;
        else          r_Btn_Prev <= i_Btn;
    end

    // ---------------- per-button press FSM ----------------
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            for (int i = 0; i < NUM_BTN; i++) r_State[i] <= IDLE;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) r_State[i] <= w_State_Nxt[i];
        end
    end

    // In HELD the previous level is always 1, so a low level is the falling edge.
    // Release is tested before the count so a release on the threshold edge is short.
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            w_State_Nxt[i] = r_State[i];
            case (r_State[i])
                IDLE:      if (w_Rise[i]) w_State_Nxt[i] = HELD;
                HELD: begin
                    if (!i_Btn[i])
                        w_State_Nxt[i] = IDLE;
                    else if (r_Cnt[i] == CNT_W'(LONG_PRESS_CYCLES - 1))
                        w_State_Nxt[i] = LONG_DONE;
                end
                LONG_DONE: if (!i_Btn[i]) w_State_Nxt[i] = IDLE;
                default:   w_State_Nxt[i] = IDLE;
            endcase
        end
    end

    always_comb begin
        w_Raise      = '0;
        w_Raise_Long = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (r_State[i] == HELD) begin
                if (!i_Btn[i]) begin
                    w_Raise[i] = 1'b1;
                end else if (r_Cnt[i] == CNT_W'(LONG_PRESS_CYCLES - 1)) begin
                    w_Raise[i]      = 1'b1;
                    w_Raise_Long[i] = 1'b1;
                end
            end
        end
    end

    // Hold counter: starts at 1 on the press edge, saturates at the threshold.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            for (int i = 0; i < NUM_BTN; i++) r_Cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                case (r_State[i])
                    IDLE:      r_Cnt[i] <= w_Rise[i] ? CNT_W'(1) : '0;
                    HELD: begin
                        if (!i_Btn[i])
                            r_Cnt[i] <= '0;
                        else if (r_Cnt[i] != CNT_W'(LONG_PRESS_CYCLES))
                            r_Cnt[i] <= r_Cnt[i] + CNT_W'(1);
                    end
                    LONG_DONE: if (!i_Btn[i]) r_Cnt[i] <= '0;
                    default:   r_Cnt[i] <= '0;
                endcase
            end
        end
    end

    // ---------------- pending flags and arbiter ----------------
    always_comb begin
        w_Grant_Vld  = 1'b0;
        w_Grant_Id   = '0;
        w_Grant_Long = 1'b0;
        // Descending scan so the lowest pending index wins.
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (r_Pend[i]) begin
                w_Grant_Vld  = 1'b1;
                w_Grant_Id   = ID_W'(i);
                w_Grant_Long = r_Pend_Long[i];
            end
        end
    end

    assign w_Pop    = evt.o_Evt_Valid && evt.i_Evt_Ready;
    assign w_Full   = (r_Count == FCNT_W'(FIFO_DEPTH));
    assign w_Wr     = w_Grant_Vld && (!w_Full || w_Pop);
    assign w_Wr_Dat = '{id: w_Grant_Id, is_long: w_Grant_Long};

    // A new event against an already-set flag is dropped even if the flag
    // is being drained this same cycle.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Pend      <= '0;
            r_Pend_Long <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (w_Raise[i] && !r_Pend[i]) begin
                    r_Pend[i]      <= 1'b1;
                    r_Pend_Long[i] <= w_Raise_Long[i];
                end else if (w_Wr && (w_Grant_Id == ID_W'(i))) begin
                    r_Pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L)                 o_Overflow <= 1'b0;
        else if (|(w_Raise & r_Pend)) o_Overflow <= 1'b1;
        else if (i_Clear_Ovf)         o_Overflow <= 1'b0;
    end

    // ---------------- show-ahead event FIFO ----------------
    always_ff @(posedge i_Clk) begin
        if (w_Wr) r_Mem[r_Wr_Ptr] <= w_Wr_Dat;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Wr_Ptr <= '0;
            r_Rd_Ptr <= '0;
            r_Count  <= '0;
            r_Last   <= '0;
        end else begin
            if (w_Wr) begin
                r_Wr_Ptr <= r_Wr_Ptr + PTR_W'(1);
                r_Last   <= w_Wr_Dat;
            end
            if (w_Pop) r_Rd_Ptr <= r_Rd_Ptr + PTR_W'(1);
            case ({w_Wr, w_Pop})
                2'b10:   r_Count <= r_Count + FCNT_W'(1);
                2'b01:   r_Count <= r_Count - FCNT_W'(1);
                default: r_Count <= r_Count;
            endcase
        end
    end

    // While empty the outputs show the last written event (zero after reset).
    assign w_Head          = (r_Count != '0) ? r_Mem[r_Rd_Ptr] : r_Last;
    assign evt.o_Evt_Valid = (r_Count != '0);
    assign evt.o_Evt_Id    = w_Head.id;
    assign evt.o_Evt_Long  = w_Head.is_long;
endmodule

// File: tb/tb_button_event_ctrl.sv
module tb_button_event_ctrl;
    localparam int NB = 4;
    localparam int L  = 8;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] btn;
    logic          ovf;
    logic          clr;

    button_event_ctrl_if #(.NUM_BTN(NB)) evt_if ();

    button_event_ctrl #(
        .NUM_BTN(NB),
        .LONG_PRESS_CYCLES(L),
        .FIFO_DEPTH(D)
    ) dut (
        .i_Clk(clk),
        .i_Rst_L(rst_n),
        .i_Btn(btn),
        .evt(evt_if),
        .o_Overflow(ovf),
        .i_Clear_Ovf(clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: press time stamps, pending flags, event queue.
    typedef struct {
        int id;
        bit lg;
    } mevt_t;

    int    cyc;
    int    press_t [NB];
    bit    fired   [NB];
    bit    prev    [NB];
    bit    pend    [NB];
    bit    pend_l  [NB];
    bit    m_ovf;
    mevt_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            prev[i] = 0; press_t[i] = -1; fired[i] = 0; pend[i] = 0; pend_l[i] = 0;
        end
        m_ovf = 0;
        q.delete();
        cyc = 0;
    endtask

    // Apply the rules for one rising edge using the inputs present at that edge.
    task automatic model_edge();
        bit    old_pend [NB];
        bit    pop, can_wr, any_drop, raise, lg;
        int    p;
        mevt_t e, dummy;
        old_pend = pend;
        pop      = (q.size() > 0) && evt_if.i_Evt_Ready;
        can_wr   = (q.size() < D) || pop;
        p = -1;
        for (int i = 0; i < NB; i++) if (pend[i] && p < 0) p = i;
        if (pop) dummy = q.pop_front();
        if (p >= 0 && can_wr) begin
            e.id = p; e.lg = pend_l[p];
            q.push_back(e);
            pend[p] = 0;
        end
        any_drop = 0;
        for (int i = 0; i < NB; i++) begin
            raise = 0; lg = 0;
            if (btn[i] && !prev[i]) begin
                press_t[i] = cyc; fired[i] = 0;
            end else if (prev[i] && btn[i] && press_t[i] >= 0 && !fired[i]
                         && (cyc - press_t[i] + 1) == L) begin
                raise = 1; lg = 1; fired[i] = 1;
            end else if (prev[i] && !btn[i] && press_t[i] >= 0) begin
                if (!fired[i]) raise = 1;
                press_t[i] = -1;
            end
            if (raise) begin
                if (old_pend[i]) any_drop = 1;
                else begin pend[i] = 1; pend_l[i] = lg; end
            end
            prev[i] = btn[i];
        end
        if (any_drop) m_ovf = 1;
        else if (clr) m_ovf = 0;
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("m_valid", evt_if.o_Evt_Valid, (q.size() > 0));
        if (q.size() > 0) begin
            chk("m_id", evt_if.o_Evt_Id, q[0].id);
            chk("m_long", evt_if.o_Evt_Long, q[0].lg);
        end
        chk("m_ovf", ovf, m_ovf);
    endtask

    task automatic press_short(input int b);
        btn = NB'(1 << b);
        step(); step();
        btn = '0;
        step(); step();
    endtask

    int exp_ids [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst_n = 1'b0; btn = '0; clr = 1'b0; evt_if.i_Evt_Ready = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", evt_if.o_Evt_Valid, 0);
        chk("rst_id", evt_if.o_Evt_Id, 0);
        chk("rst_long", evt_if.o_Evt_Long, 0);
        chk("rst_ovf", ovf, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step(); step();

        // Short press on button 2.
        evt_if.i_Evt_Ready = 1'b1;
        btn = 4'b0100;
        step(); step(); step();
        btn = '0;
        step();
        chk("t1_rel_valid", evt_if.o_Evt_Valid, 0);
        step();
        chk("t1_valid", evt_if.o_Evt_Valid, 1);
        chk("t1_id", evt_if.o_Evt_Id, 2);
        chk("t1_long", evt_if.o_Evt_Long, 0);
        step();
        chk("t1_after", evt_if.o_Evt_Valid, 0);

        // Long press on button 1.
        btn = 4'b0010;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 9) begin
                chk("t2_valid", evt_if.o_Evt_Valid, 1);
                chk("t2_id", evt_if.o_Evt_Id, 1);
                chk("t2_long", evt_if.o_Evt_Long, 1);
            end else if (k < 9) begin
                chk("t2_wait", evt_if.o_Evt_Valid, 0);
            end
        end
        btn = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2_norel", evt_if.o_Evt_Valid, 0);
        end

        // Simultaneous release of buttons 0, 1, 3.
        btn = 4'b1011;
        step(); step();
        btn = '0;
        step();
        chk("t3_rel", evt_if.o_Evt_Valid, 0);
        step(); chk("t3_v0", evt_if.o_Evt_Valid, 1); chk("t3_id0", evt_if.o_Evt_Id, 0);
        step(); chk("t3_v1", evt_if.o_Evt_Valid, 1); chk("t3_id1", evt_if.o_Evt_Id, 1);
        step(); chk("t3_v3", evt_if.o_Evt_Valid, 1); chk("t3_id3", evt_if.o_Evt_Id, 3);
        step(); chk("t3_empty", evt_if.o_Evt_Valid, 0);

        // Fill FIFO, park one pending, overflow on the next one.
        evt_if.i_Evt_Ready = 1'b0;
        for (int b = 0; b < 4; b++) press_short(b);
        chk("t4_full_head", evt_if.o_Evt_Id, 0);
        press_short(0);
        chk("t4_no_ovf", ovf, 0);
        press_short(0);
        chk("t4_ovf", ovf, 1);

        // Clear, then overflow and clear on the same edge.
        clr = 1'b1; step(); clr = 1'b0;
        chk("t5_clr", ovf, 0);
        btn = 4'b0001; step(); step();
        btn = '0; clr = 1'b1; step(); clr = 1'b0;
        chk("t5_set_wins", ovf, 1);
        step();
        chk("t5_sticky", ovf, 1);

        // Drain: 4 queued + 1 pending, in order.
        evt_if.i_Evt_Ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("t4_drain_v", evt_if.o_Evt_Valid, 1);
            chk("t4_drain_id", evt_if.o_Evt_Id, exp_ids[k]);
            step();
        end
        chk("t4_drained", evt_if.o_Evt_Valid, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NB; i++)
                if ($urandom_range(0, 11) == 0) btn[i] = ~btn[i];
            evt_if.i_Evt_Ready = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            step();
        end

        // Reset mid-hold with 2 events queued.
        btn = '0; clr = 1'b1; evt_if.i_Evt_Ready = 1'b1;
        repeat (12) step();
        clr = 1'b0; evt_if.i_Evt_Ready = 1'b0;
        press_short(1);
        press_short(2);
        chk("t6_queued", evt_if.o_Evt_Valid, 1);
        btn = 4'b0001;
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", evt_if.o_Evt_Valid, 0);
        chk("t6_rst_id", evt_if.o_Evt_Id, 0);
        chk("t6_rst_long", evt_if.o_Evt_Long, 0);
        chk("t6_rst_ovf", ovf, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("t6_long_v", evt_if.o_Evt_Valid, (k == 9));
        end
        chk("t6_id", evt_if.o_Evt_Id, 0);
        chk("t6_long", evt_if.o_Evt_Long, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/button_event_ctrl.md
# button_event_ctrl

Converts debounced push-button levels into a queue of short-press and long-press events. Sits between the per-button debounce stages and the RISC-V debug control logic (run/halt/step/reset commands). Arbitrates simultaneous presses by fixed priority, buffers events in a small FIFO, and hands them out over a valid/ready handshake.

## Interface

- NUM_BTN, 4: number of debounced button inputs (2..8).
- LONG_PRESS_CYCLES, 12500000: hold length in cycles that classifies a long press (0.5 s at 25 MHz). Minimum 2.
- FIFO_DEPTH, 4: event FIFO entries, power of two, 2..16.
- i_Clk  in  1  system clock; all logic on the rising edge.
- i_Rst_L  in  1  asynchronous active-low reset.
- i_Btn  in  NUM_BTN  debounced button levels, 1 = pressed; already synchronous to i_Clk.
- o_Evt_Valid  out  1  FIFO head holds an event.
- i_Evt_Ready  in  1  consumer accepts the head event this cycle.
- o_Evt_Id  out  $clog2(NUM_BTN)  button index of the head event.
- o_Evt_Long  out  1  1 = long press, 0 = short press.
- o_Overflow  out  1  sticky: an event was dropped.
- i_Clear_Ovf  in  1  synchronous clear of o_Overflow.

## Operation

- r_Btn_Prev registers i_Btn each cycle; resets to 0. A button held through reset is therefore seen as a new press once reset releases.
- Per-button FSM, with a hold counter that saturates at LONG_PRESS_CYCLES:
  - IDLE: on the rising edge of the button, go to HELD and set the counter to 1.
  - HELD while the button is high: increment the counter. When it reaches LONG_PRESS_CYCLES, raise a long event and go to LONG_DONE.
  - HELD when the button falls: raise a short event and go to IDLE.
  - LONG_DONE: no further events. Go to IDLE on the falling edge.
- Raising an event sets that button's pending flag and latches its long/short type.
- If a button raises an event while its pending flag is already set, the new event is dropped and o_Overflow is set.
- Arbiter: each cycle, the lowest-index pending button is written to the FIFO if a write is allowed, and its pending flag is cleared. At most one write per cycle.
  - A write is allowed when the FIFO is not full, or when a pop occurs in the same cycle.
  - When FIFO_DEPTH is full and no pop occurs, pending flags hold. Nothing is lost until a second event from the same button arrives.
- FIFO: show-ahead. The head drives o_Evt_Id/o_Evt_Long. A pop occurs when o_Evt_Valid && i_Evt_Ready. Pointers wrap modulo FIFO_DEPTH. The count register is $clog2(FIFO_DEPTH)+1 bits wide.
- o_Evt_Id/o_Evt_Long are don't-care while o_Evt_Valid = 0, but are driven to the last-written value (0 after reset).
- o_Overflow: set has priority over i_Clear_Ovf in the same cycle.
- Reset mid-operation clears all state immediately (asynchronously):
  - FSMs to IDLE, counters 0, pending flags 0.
  - FIFO empty.
  - o_Evt_Valid = 0, o_Evt_Id = 0, o_Evt_Long = 0, o_Overflow = 0.
  - In-flight events are discarded.

## Timing

- Edges are detected on the edge where i_Btn differs from r_Btn_Prev (call it edge N).
- Short event:
  - Release is sampled at edge N; pending is set at edge N.
  - The FIFO write happens at edge N+1, so o_Evt_Valid is high after N+1 (2-cycle latency) if nothing with higher priority is pending.
- Long event:
  - Press is sampled at edge P. The counter reaches LONG_PRESS_CYCLES at edge P+LONG_PRESS_CYCLES-1, and pending is set at that edge.
  - o_Evt_Valid rises one edge later.
- A release exactly at the edge where the counter would reach LONG_PRESS_CYCLES counts as short: the release is checked first.
- Pop and write in the same cycle: the count is unchanged and o_Evt_Valid stays high.
- With FIFO_DEPTH = 4 and the consumer always ready, the sustained event rate is one per cycle.

## Test plan

- LONG_PRESS_CYCLES = 8, button 2 high for 3 cycles then low, i_Evt_Ready = 1:
  - expect one event (Id = 2, Long = 0);
  - o_Evt_Valid high exactly 2 cycles after the release edge, for 1 cycle.
- Button 1 held for 20 cycles:
  - expect one event (Id = 1, Long = 1);
  - o_Evt_Valid high 8 cycles after the press edge (7 to reach the count, then 1);
  - no event on release.
- Buttons 0, 1 and 3 released in the same cycle, ready held high:
  - expect events Id 0, 1, 3 on three consecutive cycles, in that order.
- i_Evt_Ready = 0, six distinct short presses on buttons 0..3 (button 0 twice, then button 0 a third time):
  - FIFO fills to 4 entries;
  - button 0's third event with pending still set asserts o_Overflow;
  - after raising ready, exactly the 4 queued events plus 1 pending event drain, in order.
- o_Overflow set, pulse i_Clear_Ovf for 1 cycle → o_Overflow = 0. Overflow and clear in the same cycle → o_Overflow stays 1.
- Assert i_Rst_L low mid-hold (counter at 5) with 2 events queued:
  - o_Evt_Valid drops immediately;
  - after release of reset with the button still high, a fresh press is counted from 1 and the long event fires 8 cycles later.
